// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the round-robin arbiter.
// Also used by the bench for the wait bound.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

  // Longest wait a continuously held request can see.
  function automatic int wait_max(input int n, input int m);
    return (n - 1) * m + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req_i
// scanning upward from ptr_i, modulo N.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] win;
  int            j;

  // Rotated priority scan.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  assign valid_o = found;
  assign idx_o   = win;

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter with a hold limit that forces the owner
// to yield after MAX_HOLD cycles when others are waiting.
module rr_req_gnt_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        gnt,
  output logic [idx_w(N)-1:0] gnt_idx,
  output logic                busy,
  output logic                preempt
);

  localparam int IW = idx_w(N);
  localparam int CW = cnt_w(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q;
  logic          pre_q, pre_d;

  logic [N-1:0]  own_oh;
  logic [N-1:0]  pick_oh;
  logic [N-1:0]  pick_mask;
  logic [IW-1:0] pick_ptr;
  logic [IW-1:0] nxt_ptr;
  logic          owner_req;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  // Decode owner and winner indices to one-hot.
  always_comb begin
    own_oh  = '0;
    pick_oh = '0;
    for (int i = 0; i < N; i++) begin
      own_oh[i]  = (idx_q == IW'(i));
      pick_oh[i] = (pick_idx == IW'(i));
    end
  end

  // While granted, the owner is excluded and the scan starts
  // just past it, so rotation is strict after every release.
  always_comb begin
    nxt_ptr   = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
    owner_req = |(req & own_oh);
    if (state_q == GRANT) begin
      pick_mask = req & ~own_oh;
      pick_ptr  = nxt_ptr;
    end else begin
      pick_mask = req;
      pick_ptr  = ptr_q;
    end
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (pick_mask),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Grant FSM: next owner, pointer, hold counter, preempt.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          ptr_d = nxt_ptr;
          cnt_d = '0;
          if (pick_valid) begin
            gnt_d = pick_oh;
            idx_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end else if (cnt_q < HOLD_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (pick_valid) begin
            gnt_d = pick_oh;
            idx_d = pick_idx;
            pre_d = 1'b1;
            ptr_d = nxt_ptr;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      busy_q  <= |gnt_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign busy    = busy_q;
  assign preempt = pre_q;

endmodule

// File: tb/tb_rr_req_gnt_arbiter.sv
// Directed and bounded-random checks for rr_req_gnt_arbiter.
// N=4, MAX_HOLD=8.
module tb_rr_req_gnt_arbiter;
  import arb_pkg::*;

  localparam int N    = 4;
  localparam int MH   = 8;
  localparam int WMAX = wait_max(N, MH);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         busy;
  logic         preempt;

  int n_chk  = 0;
  int n_fail = 0;
  int w[N];

  rr_req_gnt_arbiter #(
    .N        (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]   rr_seq [4];
  logic [N-1:0] cur;
  logic [N-1:0] nreq;
  logic         over;

  initial begin
    rr_seq[0] = 4'b0010;
    rr_seq[1] = 4'b0100;
    rr_seq[2] = 4'b1000;
    rr_seq[3] = 4'b0001;

    // Reset values
    rst = 1'b1;
    req = '0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pre", preempt, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_ptr", dut.ptr_q, 0);
    chk("rst_cnt", dut.cnt_q, 0);

    // Single request, first grant one edge later
    rst = 1'b0;
    req = 4'b0100;
    chk("single_pre", gnt, 0);
    step();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_idx", gnt_idx, 2);
    chk("single_busy", busy, 1);
    chk("single_pre0", preempt, 0);
    req = '0;
    step();
    chk("rel_gnt", gnt, 0);
    chk("rel_busy", busy, 0);
    chk("rel_ptr", dut.ptr_q, 3);

    // Round-robin order with back-to-back handover
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    chk("rr_first", gnt, 4'b0001);
    cur = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      req = 4'b1111 & ~cur;
      step();
      chk("rr_gnt", gnt, rr_seq[k]);
      chk("rr_busy", busy, 1);
      cur = rr_seq[k];
    end
    req = '0;
    step();
    chk("rr_idle", gnt, 0);
    chk("rr_ptr", dut.ptr_q, 1);

    // Reset mid-grant, non-owner requests ignored
    req = 4'b0100;
    step();
    chk("mid_gnt", gnt, 4'b0100);
    req = 4'b0110;
    step();
    chk("mid_hold", gnt, 4'b0100);
    chk("mid_idx", gnt_idx, 2);
    rst = 1'b1;
    step();
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ptr", dut.ptr_q, 0);
    chk("mid_rst_pre", preempt, 0);
    rst = 1'b0;
    step();
    chk("mid_rearb", gnt, 4'b0010);
    chk("mid_rearb_idx", gnt_idx, 1);
    req = 4'b0100;
    step();
    chk("mid_next", gnt, 4'b0100);
    req = '0;
    step();

    // Forced release between two holders
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0011;
    step();
    chk("frc_g0", gnt, 4'b0001);
    for (int c = 1; c < MH; c++) begin
      step();
      chk("frc_hold0", gnt, 4'b0001);
      chk("frc_nopre0", preempt, 0);
    end
    step();
    chk("frc_g1", gnt, 4'b0010);
    chk("frc_pre1", preempt, 1);
    chk("frc_ptr1", dut.ptr_q, 1);
    for (int c = 1; c < MH; c++) begin
      step();
      chk("frc_hold1", gnt, 4'b0010);
      chk("frc_nopre1", preempt, 0);
    end
    step();
    chk("frc_back0", gnt, 4'b0001);
    chk("frc_pre2", preempt, 1);
    step();
    chk("frc_pulse", preempt, 0);
    chk("frc_keep0", gnt, 4'b0001);
    req = '0;
    step();

    // Lone holder keeps grant, counter clears
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1000;
    step();
    chk("lone_gnt", gnt, 4'b1000);
    chk("lone_cnt0", dut.cnt_q, 0);
    for (int c = 1; c <= 30; c++) begin
      step();
      chk("lone_hold", gnt, 4'b1000);
      chk("lone_nopre", preempt, 0);
      chk("lone_cnt", dut.cnt_q, c % MH);
    end
    req = '0;
    step();

    // Random traffic: bound on waiting, one-hot grant
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) w[i] = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      nreq = req;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (gnt[i] && $urandom_range(3) == 0) nreq[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          nreq[i] = 1'b1;
          chk("rise_gnt", gnt[i], 0);
        end
      end
      req = nreq;
      step();
      chk("onehot", $onehot0(gnt), 1);
      over = 1'b0;
      for (int i = 0; i < N; i++) begin
        w[i] = (req[i] && !gnt[i]) ? w[i] + 1 : 0;
        if (w[i] > WMAX) over = 1'b1;
      end
      chk("wait_bound", over, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
